// File: rtl/fp_alu_sched.sv
// fp_alu_sched: round-robin scheduler sharing one fixed-point add/sub/mul/div unit
// between NREQ requesters, with a serial restoring divider and a backpressured response.
module fp_alu_sched #(
  parameter int N    = 32,
  parameter int Q    = 16,
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [N*NREQ-1:0]       req_a,
  input  logic [N*NREQ-1:0]       req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [N-1:0]            rsp_data,
  output logic                    rsp_dbz,
  output logic                    busy
);
  localparam int IW = $clog2(NREQ);
  localparam int DW = N + Q;
  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t          state_q;
  logic [IW-1:0]   rr_q;
  logic [IW-1:0]   id_q;
  logic [N-1:0]    bmag_q;
  logic            sign_q;
  logic [N-1:0]    rem_q;
  logic [DW-1:0]   dvd_q;
  logic [CW-1:0]   cnt_q;
  logic            rsp_valid_q;
  logic            rsp_dbz_q;
  logic [IW-1:0]   rsp_id_q;
  logic [N-1:0]    rsp_data_q;

  logic            grant_vld;
  logic [IW-1:0]   grant_id;
  logic [IW:0]     scan_idx;

  // Rotating priority: first pending requester at or after rr, wrapping modulo NREQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, rr_q} + (IW+1)'(k);
      if (scan_idx >= (IW+1)'(NREQ)) scan_idx = scan_idx - (IW+1)'(NREQ);
      if (!grant_vld && req_valid[scan_idx[IW-1:0]]) begin
        grant_vld = 1'b1;
        grant_id  = scan_idx[IW-1:0];
      end
    end
  end

  logic [1:0]     sel_op;
  logic [N-1:0]   sel_a, sel_b, amag, bmag, mul_mag, res_d;
  logic [2*N-1:0] prod;
  logic           sgn, dbz_d, div_run;

  always_comb begin
    sel_op  = req_op[2*grant_id +: 2];
    sel_a   = req_a[N*grant_id +: N];
    sel_b   = req_b[N*grant_id +: N];
    amag    = sel_a[N-1] ? -sel_a : sel_a;
    bmag    = sel_b[N-1] ? -sel_b : sel_b;
    sgn     = sel_a[N-1] ^ sel_b[N-1];
    prod    = {{N{1'b0}}, amag} * {{N{1'b0}}, bmag};
    mul_mag = N'(prod >> Q);
    div_run = (sel_op == 2'b11) && (sel_b != '0);
    dbz_d   = 1'b0;
    case (sel_op)
      2'b00:   res_d = sel_a + sel_b;
      2'b01:   res_d = sel_a + (~sel_b + 1'b1);
      2'b10:   res_d = sgn ? -mul_mag : mul_mag;
      default: begin
        // Only reached as a result when b is zero: saturate toward the sign of a.
        dbz_d = (sel_b == '0);
        res_d = sel_a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      end
    endcase
  end

  // One restoring step: quotient bits shift into dvd_q as dividend bits leave it.
  logic [N:0]    rem_ext, rem_diff;
  logic          q_bit;
  logic [N-1:0]  rem_d, quo_signed;
  logic [DW-1:0] dvd_d;

  always_comb begin
    rem_ext    = {rem_q, dvd_q[DW-1]};
    rem_diff   = rem_ext - {1'b0, bmag_q};
    q_bit      = ~rem_diff[N];
    rem_d      = q_bit ? rem_diff[N-1:0] : rem_ext[N-1:0];
    dvd_d      = {dvd_q[DW-2:0], q_bit};
    quo_signed = sign_q ? -dvd_d[N-1:0] : dvd_d[N-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      id_q        <= '0;
      bmag_q      <= '0;
      sign_q      <= 1'b0;
      rem_q       <= '0;
      dvd_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dbz_q   <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (grant_vld) begin
          rr_q <= (grant_id == IW'(NREQ-1)) ? '0 : grant_id + 1'b1;
          id_q <= grant_id;
          if (div_run) begin
            bmag_q  <= bmag;
            sign_q  <= sgn;
            rem_q   <= '0;
            dvd_q   <= {amag, {Q{1'b0}}};
            cnt_q   <= '0;
            state_q <= DIV;
          end else begin
            rsp_data_q  <= res_d;
            rsp_dbz_q   <= dbz_d;
            rsp_id_q    <= grant_id;
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DIV: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(DW-1)) begin
            rsp_data_q  <= quo_signed;
            rsp_dbz_q   <= 1'b0;
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          rsp_dbz_q   <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE && grant_vld && rst_n) ? (NREQ'(1) << grant_id) : '0;
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_dbz   = rsp_dbz_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
endmodule

// File: doc/fp_alu_sched.md
# fp_alu_sched

Multi-cycle scheduler that shares one fixed-point arithmetic unit (add, sub, mul, div) between NREQ requesters in the physics simulator datapath. Each requester presents an operation through a valid/ready port. A round-robin arbiter picks one request; the block executes it (single-cycle for add/sub/mul, iterative shift-subtract for div) and returns the result, tagged with the requester index, on one shared response channel with backpressure. It sits between the per-body force/integration engines and the arithmetic, replacing per-engine combinational dividers.

## Interface
- N, 32, operand/result width, two's-complement fixed point
- Q, 16, fractional bits (Q ≤ N−1)
- NREQ, 4, number of requesters (≥ 2)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  NREQ  request pending, one bit per requester
- req_ready  out  NREQ  grant/accept strobe, one-hot or zero
- req_op  in  2·NREQ  opcode per requester, slice [2i+1:2i]: 00 add, 01 sub, 10 mul, 11 div
- req_a, req_b  in  N·NREQ  operands per requester, slice [N·i+N−1:N·i]
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  $clog2(NREQ)  index of the requester that owns rsp_data
- rsp_data  out  N  result
- rsp_dbz  out  1  division by zero flag, qualified by rsp_valid
- busy  out  1  high whenever state ≠ IDLE

## Operation
- FSM states are IDLE, DIV, DONE. Reset state is IDLE, rr pointer 0, all outputs 0.
- IDLE:
  - Grant goes to the first i with req_valid[i], scanning from rr upward, modulo NREQ.
  - req_ready[i] is combinational, high only in IDLE, only for the granted i.
  - On accept (valid & ready), latch op, a, b and id, and set rr = (i+1) mod NREQ.
  - add/sub/mul, and div with b = 0, compute during the accept cycle, register the result and go to DONE.
  - div with b ≠ 0 goes to DIV.
- Arithmetic (all results truncate/wrap to N bits; no saturation except divide by zero):
  - add: a+b.
  - sub: a+(~b+1).
  - mul: sign = a[N−1]^b[N−1]. Take the 2N-bit product of the magnitudes, select bits [N+Q−1:Q], then negate if sign.
  - div: sign as mul. Quotient = (|a|<<Q)/|b|, low N bits kept, negated if sign.
  - Divide by zero: rsp_dbz=1, rsp_data = 0x7FF…F if a ≥ 0, else 0x800…0.
- DIV:
  - Restoring divider over the (N+Q)-bit dividend |a|<<Q, one quotient bit per cycle.
  - Runs exactly N+Q cycles with a cycle counter, then applies sign and goes to DONE.
  - Result bits must match the divide equation above exactly.
- DONE:
  - Hold rsp_valid, rsp_id, rsp_data and rsp_dbz stable until rsp_ready.
  - On handshake, go to IDLE and drop rsp_valid and rsp_dbz.
  - No new grant in DONE or DIV.
- Requesters hold req_valid, req_op and operands stable until accepted. Deasserting req_valid before accept is allowed and withdraws the request.
- Magnitude of the most-negative value wraps (|0x800…0| = 0x800…0 treated as unsigned 2^(N−1)). This is legal and must not hang.
- Reset mid-operation clears the FSM, counter, rr and outputs immediately. In-flight results are discarded.

## Timing
- Accept at edge t:
  - add/sub/mul/dbz: rsp_valid high from t+1.
  - div: rsp_valid high from t+1+N+Q (49 cycles for defaults).
- rsp_ready held high: IDLE again at t+2 (non-div). Peak throughput is one non-div op per 2 cycles.
- rsp_ready low: response holds indefinitely with outputs unchanged, and busy stays high.
- rsp_ready while rsp_valid=0 is ignored.
- req_ready never asserts in the cycle rsp handshake completes; the next grant is in the following cycle.

## Test plan
- After reset, all outputs 0. Req1 add 0x00018000+0x00020000 → rsp_valid 1 cycle after accept, rsp_id=1, rsp_data=0x00038000, rsp_dbz=0.
- mul 1.5×2.0 (0x00018000, 0x00020000) → 0x00030000. mul −1.5×2.0 → 0xFFFD0000. add 0x7FFFFFFF+0x00000001 → 0x80000000 (wrap).
- div 0xFFFD0000/0x00020000 → 0xFFFE8000 exactly 49 cycles after accept. div 1/0: a=0x00010000, b=0 → 0x7FFFFFFF, rsp_dbz=1, latency 1.
- All four req_valid held high, rsp_ready=1 → grants in order 0,1,2,3,0 with one accept per 2 cycles. Withdraw req2 → order 0,1,3.
- Hold rsp_ready=0 for 10 cycles after a result → rsp_* stable, req_ready all 0, busy=1. Release → handshake, then next grant one cycle later.
- Assert rst_n=0 mid-DIV (cycle 20) → busy, rsp_valid and req_ready 0 immediately. After release, the first grant goes to requester 0.
